// File: rtl/cplx_pkg.sv
// rtl/cplx_pkg.sv - shared state encoding and bit-reverse helper for the complex shift buffer
package cplx_pkg;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   localparam int CPLX_DW_DEF    = 10;
   localparam int CPLX_DEPTH_DEF = 8;

   // Reverses the low aw bits of v; bits at and above aw come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int aw);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < aw) r[5'(i)] = v[5'(aw - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/cplx_mux_n.sv
// rtl/cplx_mux_n.sv - DEPTH:1 complex read multiplexer over a flattened {re, im} entry vector
module cplx_mux_n #(
   parameter int DW    = 10,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [DEPTH*2*DW-1:0] i_data,
   input  logic [AW-1:0]         i_sel,
   output logic [DW-1:0]         o_re,
   output logic [DW-1:0]         o_im
);

   logic [2*DW-1:0] w_word;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_sel == AW'(i)) w_word = i_data[i*2*DW +: 2*DW];
      end
   end

   assign o_re = w_word[2*DW-1:DW];
   assign o_im = w_word[DW-1:0];

endmodule

// File: rtl/cplx_shift_buffer.sv
// rtl/cplx_shift_buffer.sv - DEPTH-sample complex frame buffer: shift-in fill, whole-frame drain, random tap read
// CSB_BITREV_EN selects bit-reversed drain order instead of arrival order.
module cplx_shift_buffer
   import cplx_pkg::*;
#(
   parameter int DW    = CPLX_DW_DEF,
   parameter int DEPTH = CPLX_DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          in_ready,
   input  logic [AW-1:0] sel,
   output logic [DW-1:0] tap_re,
   output logic [DW-1:0] tap_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          full,
   output logic [AW:0]   count
);

   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } cplx_t;

   localparam logic [AW:0]   LP_LAST_CNT = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] LP_LAST_RD  = AW'(DEPTH - 1);

   cplx_t                 r_entry [DEPTH];
   state_e                r_state;
   logic                  r_in_ready;
   logic                  r_full;
   logic [AW:0]           r_count;
   logic [AW-1:0]         r_rd;
   logic [DEPTH*2*DW-1:0] w_flat;
   logic [AW-1:0]         w_drain_sel;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_flat[g*2*DW +: 2*DW] = r_entry[g];
   end

   // DEPTH is a power of two, so DEPTH-1-x is simply the bitwise complement of x.
`ifdef CSB_BITREV_EN
   assign w_drain_sel = ~AW'(bitrev(32'(r_rd), AW));
`else
   assign w_drain_sel = ~r_rd;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_FILL;
         r_in_ready <= 1'b1;
         r_full     <= 1'b0;
         r_count    <= '0;
         r_rd       <= '0;
         for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      end else if (clr) begin
         r_state    <= ST_FILL;
         r_in_ready <= 1'b1;
         r_full     <= 1'b0;
         r_count    <= '0;
         r_rd       <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (in_valid) begin
                  r_entry[0] <= '{re: in_re, im: in_im};
                  for (int i = 1; i < DEPTH; i++) r_entry[i] <= r_entry[i-1];
                  r_count <= r_count + 1'b1;
                  if (r_count == LP_LAST_CNT) begin
                     r_state    <= ST_DRAIN;
                     r_in_ready <= 1'b0;
                     r_full     <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (r_rd == LP_LAST_RD) begin
                     r_state    <= ST_FILL;
                     r_in_ready <= 1'b1;
                     r_full     <= 1'b0;
                     r_count    <= '0;
                     r_rd       <= '0;
                  end else begin
                     r_rd    <= r_rd + 1'b1;
                     r_count <= r_count - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   cplx_mux_n #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_tap_mux (
      .i_data (w_flat),
      .i_sel  (sel),
      .o_re   (tap_re),
      .o_im   (tap_im)
   );

   cplx_mux_n #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_drain_mux (
      .i_data (w_flat),
      .i_sel  (w_drain_sel),
      .o_re   (out_re),
      .o_im   (out_im)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_full;
   assign full      = r_full;
   assign count     = r_count;

endmodule

// File: tb/tb_cplx_shift_buffer.sv
// tb/tb_cplx_shift_buffer.sv - scoreboard bench for cplx_shift_buffer (honours CSB_BITREV_EN in its model)
module tb_cplx_shift_buffer;

   localparam int DW    = 10;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst, clr, in_valid, out_ready;
   logic          in_ready, out_valid, full;
   logic [DW-1:0] in_re, in_im, tap_re, tap_im, out_re, out_im;
   logic [AW-1:0] sel;
   logic [AW:0]   count;

   typedef struct {
      int re;
      int im;
   } smp_t;

   smp_t exp_q[$];
   smp_t frame[$];
   smp_t hist[DEPTH];
   bit   m_drain;
   int   m_count;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   cplx_shift_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_ready  (in_ready),
      .sel       (sel),
      .tap_re    (tap_re),
      .tap_im    (tap_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .full      (full),
      .count     (count)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Position in the frame (arrival index) emitted as the k-th drain sample.
   function automatic int drain_pos(input int k);
      int r;
`ifdef CSB_BITREV_EN
      r = 0;
      for (int b = 0; b < AW; b++) r += ((k >> b) & 1) << (AW - 1 - b);
`else
      r = k;
`endif
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) hist[i] = '{0, 0};
      frame.delete();
      exp_q.delete();
      m_drain = 0;
      m_count = 0;
   endtask

   // One cycle: drive inputs, check state-level outputs, advance the model, cross the edge.
   task automatic step(input bit iv, input int re, input int im, input bit ordy, input bit c, input int s);
      smp_t smp;
      in_valid  = iv;
      in_re     = DW'(re);
      in_im     = DW'(im);
      out_ready = ordy;
      clr       = c;
      sel       = AW'(s);
      #1;
      chk("in_ready", int'(in_ready), int'(!m_drain));
      chk("out_valid", int'(out_valid), int'(m_drain));
      chk("full", int'(full), int'(m_drain));
      chk("count", int'(count), m_count);
      chk("tap_re", int'(tap_re), hist[s].re);
      chk("tap_im", int'(tap_im), hist[s].im);
      if (c) begin
         m_drain = 0;
         m_count = 0;
         frame.delete();
         exp_q.delete();
      end else if (!m_drain && iv) begin
         smp = '{re & 10'h3ff, im & 10'h3ff};
         for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = smp;
         frame.push_back(smp);
         m_count++;
         if (m_count == DEPTH) begin
            m_drain = 1;
            for (int k = 0; k < DEPTH; k++) exp_q.push_back(frame[drain_pos(k)]);
            frame.delete();
         end
      end else if (m_drain && ordy) begin
         m_count--;
         if (m_count == 0) m_drain = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int s);
      step(0, 0, 0, 0, 0, s);
   endtask

   task automatic fill(input int base, input int imb);
      for (int k = 0; k < DEPTH; k++) step(1, base + k, imb + k, 0, 0, k);
   endtask

   task automatic async_rst();
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_full", int'(full), 0);
      chk("arst_count", int'(count), 0);
      chk("arst_tap_re", int'(tap_re), 0);
      chk("arst_out_re", int'(out_re), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Drain-data monitor: compares the presented sample to the scoreboard head, pops on handshake.
   always @(negedge clk) begin
      if (!rst && !clr && out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_unexpected: out_valid with no expected sample, out_re=%0d", out_re);
         end else begin
            chk("out_re", int'(out_re), exp_q[0].re);
            chk("out_im", int'(out_im), exp_q[0].im);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required<100000", $time);
      $fatal(1);
   end

   initial begin
      int guard;
      rst = 1'b1; clr = 0; in_valid = 0; out_ready = 0; in_re = 0; in_im = 0; sel = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_out_re", int'(out_re), 0);
      chk("rst_tap_im", int'(tap_im), 0);
      rst = 1'b0;

      fill(0, 100);
      for (int s = 0; s < DEPTH; s++) idle(s);
      repeat (DEPTH) step(0, 0, 0, 1, 0, 0);
      idle(0);

      fill(0, 100);
      for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, 0, (i % 2) == 0, 0, i % DEPTH);
      idle(3);

      for (int k = 0; k < 3; k++) step(1, 40 + k, 300 + k, 0, 0, k);
      async_rst();
      fill(20, 120);
      repeat (DEPTH) step(0, 0, 0, 1, 0, 5);
      idle(0);

      for (int k = 0; k < 5; k++) step(1, 60 + k, 200 + k, 0, 0, k);
      step(1, 99, 99, 0, 1, 0);
      idle(0);
      fill(30, 130);
      repeat (3) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 2);
      idle(2);

      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, DEPTH - 1));

      guard = 0;
      while (m_drain && guard < 4 * DEPTH) begin
         step(0, 0, 0, 1, 0, 0);
         guard++;
      end
      idle(0);
      chk("drain_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
